// File: rtl/rtc_apb_ctrl.sv
// APB register front-end for the RTC time-of-day block: BCD-checked writes become
// single-cycle update pulses with held data; also owns the day counter and interrupt logic.
module rtc_apb_ctrl #(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      clock_update_o,
    output logic [21:0]               clock_o,
    input  logic [21:0]               clock_i,
    output logic [9:0]                init_sec_cnt_o,
    output logic                      timer_update_o,
    output logic                      timer_enable_o,
    output logic                      timer_retrig_o,
    output logic [16:0]               timer_target_o,
    input  logic [16:0]               timer_value_i,
    output logic                      alarm_update_o,
    output logic                      alarm_enable_o,
    output logic [21:0]               alarm_clock_o,
    input  logic [21:0]               alarm_clock_i,
    input  logic                      event_i,
    input  logic                      update_day_i,
    output logic                      irq_o
);

    typedef enum logic [1:0] {IDLE, PULSE, DONE} state_t;
    typedef enum logic [2:0] {
        REG_CLOCK, REG_ALARM, REG_TIMER_CFG, REG_TIMER_VAL,
        REG_IRQ_STATUS, REG_IRQ_MASK, REG_DAY_CNT, REG_SEC_INIT
    } reg_t;

    // hh may only reach 23, ss/mm 59, and every digit must be decimal
    function automatic logic bcd_ok(input logic [21:0] v);
        logic units_ok, tens_ok;
        units_ok = (v[3:0] <= 4'd9) && (v[11:8] <= 4'd9) && (v[19:16] <= 4'd9);
        tens_ok  = (v[7:4] <= 4'd5) && (v[15:12] <= 4'd5) &&
                   ((v[21:20] < 2'd2) || ((v[21:20] == 2'd2) && (v[19:16] <= 4'd3)));
        return units_ok && tens_ok;
    endfunction

    state_t      state;
    reg_t        addr;
    logic        access, wr_acc, rd_acc, idle;
    logic        wr_err, start, reg_wr;
    logic        clock_upd_q, alarm_upd_q, timer_upd_q;
    logic [21:0] clock_q, alarm_clock_q;
    logic        alarm_en_q, timer_en_q, timer_retrig_q;
    logic [16:0] timer_target_q;
    logic [9:0]  sec_init_q;
    logic [15:0] day_cnt, day_shadow;
    logic [1:0]  status, mask, status_clr;
    logic        irq_q;
    logic        unused_bits;

    assign unused_bits = ^{paddr_i[APB_ADDR_WIDTH-1:5], paddr_i[1:0], pwdata_i[29:22]};

    assign addr   = reg_t'(paddr_i[4:2]);
    assign access = psel_i & penable_i;
    assign wr_acc = access & pwrite_i;
    assign rd_acc = access & ~pwrite_i;
    assign idle   = (state == IDLE);

    assign wr_err = wr_acc & ((addr == REG_TIMER_VAL) |
                    (((addr == REG_CLOCK) | (addr == REG_ALARM)) & ~bcd_ok(pwdata_i[21:0])));
    assign start  = idle & wr_acc & ~wr_err & (addr inside {REG_CLOCK, REG_ALARM, REG_TIMER_CFG});
    assign reg_wr = idle & wr_acc & ~wr_err;

    // Update writes stall until DONE; everything else finishes in its first access cycle
    assign pready_o  = (state == DONE) | (idle & access & ~start);
    assign pslverr_o = idle & wr_err;

    always_comb begin
        prdata_o = '0;
        if (psel_i && !pwrite_i) begin
            case (addr)
                REG_CLOCK:      prdata_o = {10'b0, clock_i};
                REG_ALARM:      prdata_o = {alarm_en_q, 9'b0, alarm_clock_i};
                REG_TIMER_CFG:  prdata_o = {timer_en_q, timer_retrig_q, 13'b0, timer_target_q};
                REG_TIMER_VAL:  prdata_o = {15'b0, timer_value_i};
                REG_IRQ_STATUS: prdata_o = {30'b0, status};
                REG_IRQ_MASK:   prdata_o = {30'b0, mask};
                REG_DAY_CNT:    prdata_o = {16'b0, day_shadow};
                REG_SEC_INIT:   prdata_o = {22'b0, sec_init_q};
            endcase
        end
    end

    // NOTE: every register below uses non-blocking assignments so all state updates
    // see pre-edge values, and the async reset clears them without waiting for a clock.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            clock_upd_q    <= 1'b0;
            alarm_upd_q    <= 1'b0;
            timer_upd_q    <= 1'b0;
            clock_q        <= '0;
            alarm_clock_q  <= '0;
            alarm_en_q     <= 1'b0;
            timer_en_q     <= 1'b0;
            timer_retrig_q <= 1'b0;
            timer_target_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    case (addr)
                        REG_CLOCK: begin
                            clock_q     <= pwdata_i[21:0];
                            clock_upd_q <= 1'b1;
                        end
                        REG_ALARM: begin
                            alarm_en_q    <= pwdata_i[31];
                            alarm_clock_q <= pwdata_i[21:0];
                            alarm_upd_q   <= 1'b1;
                        end
                        default: begin
                            timer_en_q     <= pwdata_i[31];
                            timer_retrig_q <= pwdata_i[30];
                            timer_target_q <= pwdata_i[16:0];
                            timer_upd_q    <= 1'b1;
                        end
                    endcase
                    state <= PULSE;
                end
                PULSE: begin
                    clock_upd_q <= 1'b0;
                    alarm_upd_q <= 1'b0;
                    timer_upd_q <= 1'b0;
                    state       <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Hardware set takes priority over a software clear in the same cycle
    assign status_clr = (reg_wr && addr == REG_IRQ_STATUS) ? pwdata_i[1:0] : 2'b00;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mask       <= '0;
            sec_init_q <= '0;
            day_cnt    <= '0;
            day_shadow <= '0;
            status     <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (reg_wr && addr == REG_IRQ_MASK) mask <= pwdata_i[1:0];
            if (reg_wr && addr == REG_SEC_INIT) sec_init_q <= pwdata_i[9:0];
            if (reg_wr && addr == REG_DAY_CNT) day_cnt <= pwdata_i[15:0];
            else if (update_day_i)              day_cnt <= day_cnt + 16'd1;
            // A CLOCK read freezes the day count so software sees a matching pair
            if (idle && rd_acc && addr == REG_CLOCK) day_shadow <= day_cnt;
            status <= (status & ~status_clr) | {update_day_i, event_i};
            irq_q  <= |(status & mask);
        end
    end

    assign clock_update_o = clock_upd_q;
    assign alarm_update_o = alarm_upd_q;
    assign timer_update_o = timer_upd_q;
    assign clock_o        = clock_q;
    assign alarm_clock_o  = alarm_clock_q;
    assign alarm_enable_o = alarm_en_q;
    assign timer_enable_o = timer_en_q;
    assign timer_retrig_o = timer_retrig_q;
    assign timer_target_o = timer_target_q;
    assign init_sec_cnt_o = sec_init_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_rtc_apb_ctrl.sv
// Self-checking bench for rtc_apb_ctrl: directed scenarios plus randomized APB traffic
// compared against a behavioural register model.
module tb_rtc_apb_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic        clock_update, timer_update, alarm_update;
    logic [21:0] clock_out, clock_in, alarm_clock_out, alarm_clock_in;
    logic [9:0]  init_sec_cnt;
    logic        timer_enable, timer_retrig, alarm_enable;
    logic [16:0] timer_target, timer_value;
    logic        event_in, update_day, irq;

    rtc_apb_ctrl #(.APB_ADDR_WIDTH(12)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
        .pready_o(pready), .pslverr_o(pslverr),
        .clock_update_o(clock_update), .clock_o(clock_out), .clock_i(clock_in),
        .init_sec_cnt_o(init_sec_cnt),
        .timer_update_o(timer_update), .timer_enable_o(timer_enable),
        .timer_retrig_o(timer_retrig), .timer_target_o(timer_target),
        .timer_value_i(timer_value),
        .alarm_update_o(alarm_update), .alarm_enable_o(alarm_enable),
        .alarm_clock_o(alarm_clock_out), .alarm_clock_i(alarm_clock_in),
        .event_i(event_in), .update_day_i(update_day), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [21:0] m_clock, m_alarm;
    logic        m_aen, m_ten, m_tre;
    logic [16:0] m_tgt;
    logic [1:0]  m_status, m_mask;
    int          m_day, m_shadow;
    logic [9:0]  m_sec;

    // Results of the last transfer
    int          t_cycles, t_pulses, t_pulse_cyc;
    logic        t_done, t_err_any;
    logic [2:0]  t_which;
    logic [31:0] t_rdata;
    logic [21:0] s_clock, s_alarm;
    logic        s_aen, s_ten, s_tre;
    logic [16:0] s_tgt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] make_bcd(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Decode the six digits numerically and test the time-of-day ranges
    function automatic bit bcd_valid(input logic [21:0] v);
        int d[6];
        d[0] = 32'(v[3:0]);   d[1] = 32'(v[7:4]);
        d[2] = 32'(v[11:8]);  d[3] = 32'(v[15:12]);
        d[4] = 32'(v[19:16]); d[5] = 32'(v[21:20]);
        foreach (d[i]) if (d[i] > 9) return 1'b0;
        return (d[1] * 10 + d[0] < 60) && (d[3] * 10 + d[2] < 60) && (d[5] * 10 + d[4] < 24);
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {10'b0, clock_in};
            3'd1:    return {m_aen, 9'b0, alarm_clock_in};
            3'd2:    return {m_ten, m_tre, 13'b0, m_tgt};
            3'd3:    return {15'b0, timer_value};
            3'd4:    return {30'b0, m_status};
            3'd5:    return {30'b0, m_mask};
            3'd6:    return 32'(m_shadow);
            default: return {22'b0, m_sec};
        endcase
    endfunction

    task automatic model_reset();
        m_clock = '0; m_alarm = '0; m_aen = 0; m_ten = 0; m_tre = 0; m_tgt = '0;
        m_status = '0; m_mask = '0; m_day = 0; m_shadow = 0; m_sec = '0;
    endtask

    task automatic check_held();
        check("clock_o", 32'(clock_out), 32'(m_clock));
        check("alarm_clock_o", 32'(alarm_clock_out), 32'(m_alarm));
        check("alarm_enable_o", 32'(alarm_enable), 32'(m_aen));
        check("timer_cfg_o", {timer_enable, timer_retrig, 13'b0, timer_target}, {m_ten, m_tre, 13'b0, m_tgt});
        check("init_sec_cnt_o", 32'(init_sec_cnt), 32'(m_sec));
    endtask

    task automatic check_quiet_outputs();
        check_held();
        check("pulses_idle", 32'({clock_update, alarm_update, timer_update}), 32'd0);
        check("pready_idle", 32'(pready), 32'd0);
        check("pslverr_idle", 32'(pslverr), 32'd0);
        check("prdata_idle", prdata, 32'd0);
        check("irq_idle", 32'(irq), 32'(|(m_status & m_mask)));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_irq();
        idle(1);
        check("irq", 32'(irq), 32'(|(m_status & m_mask)));
    endtask

    // One APB transfer; ev raises event_i during the access phase
    task automatic apb(input logic wr, input logic [2:0] a, input logic [31:0] d, input logic ev);
        @(negedge clk);
        psel = 1; penable = 0; pwrite = wr; paddr = {7'b0, a, 2'b00}; pwdata = d;
        @(negedge clk);
        penable = 1; event_in = ev;
        t_cycles = 0; t_pulses = 0; t_pulse_cyc = 0; t_which = '0;
        t_done = 0; t_err_any = 0; t_rdata = '0;
        for (int i = 0; i < 8 && !t_done; i++) begin
            #1;
            t_cycles++;
            if (clock_update | alarm_update | timer_update) begin
                t_pulses += 32'(clock_update) + 32'(alarm_update) + 32'(timer_update);
                t_which = {clock_update, alarm_update, timer_update};
                t_pulse_cyc = t_cycles;
                s_clock = clock_out; s_alarm = alarm_clock_out; s_aen = alarm_enable;
                s_ten = timer_enable; s_tre = timer_retrig; s_tgt = timer_target;
            end
            if (pslverr) t_err_any = 1;
            if (pready) begin
                t_done = 1;
                t_rdata = prdata;
            end else begin
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        psel = 0; penable = 0; pwrite = 0; event_in = 0;
    endtask

    task automatic xfer(input logic wr, input logic [2:0] a, input logic [31:0] d, input logic ev);
        logic        exp_err, exp_upd, old_irq;
        logic [31:0] exp_rdata;
        logic [1:0]  clr;
        exp_err   = wr && ((a == 3'd3) || ((a <= 3'd1) && !bcd_valid(d[21:0])));
        exp_upd   = wr && (a <= 3'd2) && !exp_err;
        exp_rdata = wr ? 32'd0 : model_read(a);
        old_irq   = |(m_status & m_mask);
        apb(wr, a, d, ev);
        check("completed", 32'(t_done), 32'd1);
        check("access_cycles", 32'(t_cycles), exp_upd ? 32'd3 : 32'd1);
        check("pslverr", 32'(t_err_any), 32'(exp_err));
        check("prdata", t_rdata, exp_rdata);
        check("pulse_count", 32'(t_pulses), exp_upd ? 32'd1 : 32'd0);
        check("irq_lag", 32'(irq), 32'(old_irq));
        if (exp_upd) begin
            check("pulse_cycle", 32'(t_pulse_cyc), 32'd2);
            check("pulse_which", 32'(t_which), (a == 3'd0) ? 32'd4 : (a == 3'd1) ? 32'd2 : 32'd1);
            case (a)
                3'd0: check("clock_at_pulse", 32'(s_clock), 32'(d[21:0]));
                3'd1: check("alarm_at_pulse", {s_aen, 9'b0, s_alarm}, {d[31], 9'b0, d[21:0]});
                default: check("timer_at_pulse", {s_ten, s_tre, 13'b0, s_tgt}, {d[31:30], 13'b0, d[16:0]});
            endcase
        end
        clr = 2'b00;
        if (wr && !exp_err) begin
            case (a)
                3'd0: m_clock = d[21:0];
                3'd1: begin m_aen = d[31]; m_alarm = d[21:0]; end
                3'd2: begin m_ten = d[31]; m_tre = d[30]; m_tgt = d[16:0]; end
                3'd4: clr = d[1:0];
                3'd5: m_mask = d[1:0];
                3'd6: m_day = 32'(d[15:0]);
                3'd7: m_sec = d[9:0];
                default: ;
            endcase
        end
        if (!wr && a == 3'd0) m_shadow = m_day;
        m_status = (m_status & ~clr) | {1'b0, ev};
        check_held();
    endtask

    task automatic pulse_inputs(input logic ev, input logic ud);
        @(negedge clk);
        event_in = ev; update_day = ud;
        @(posedge clk);
        #1;
        event_in = 0; update_day = 0;
        if (ud) m_day = (m_day + 1) % 65536;
        m_status = m_status | {ud, ev};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  a;
        logic        wr;
        logic [31:0] d;

        rstn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        clock_in = 22'h081533; alarm_clock_in = 22'h070000; timer_value = 17'h1abcd;
        event_in = 0; update_day = 0;
        model_reset();
        #22 rstn = 1;
        @(negedge clk); #1;
        check_quiet_outputs();

        // Valid clock load, then two rejected BCD values
        xfer(1, 3'd0, 32'h0012_3059, 0);
        xfer(1, 3'd0, 32'h0024_5900, 0);
        xfer(1, 3'd1, 32'h0000_005A, 0);
        check("clock_unchanged", 32'(clock_out), 32'h0012_3059);

        // Timer configuration, read and illegal write of the live timer count
        xfer(1, 3'd2, 32'hC000_0010, 0);
        check("timer_target", 32'(timer_target), 32'h10);
        xfer(0, 3'd3, 32'd0, 0);
        xfer(1, 3'd3, 32'h1234, 0);

        // Day counter wrap and coherent clock/day read
        xfer(1, 3'd6, 32'h0000_FFFF, 0);
        pulse_inputs(0, 1);
        xfer(0, 3'd0, 32'd0, 0);
        xfer(0, 3'd6, 32'd0, 0);
        check("day_wrapped", t_rdata, 32'd0);
        xfer(0, 3'd4, 32'd0, 0);
        check("status_day", t_rdata, 32'd2);
        xfer(1, 3'd5, 32'h2, 0);
        check_irq();

        // Event set beats a simultaneous clear; a later clear drops irq one cycle on
        xfer(1, 3'd5, 32'h3, 0);
        xfer(1, 3'd4, 32'h3, 0);
        pulse_inputs(1, 0);
        check_irq();
        xfer(1, 3'd4, 32'h1, 1);
        xfer(0, 3'd4, 32'd0, 0);
        check("status_set_wins", t_rdata, 32'd1);
        xfer(1, 3'd4, 32'h1, 0);
        check_irq();

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            clock_in       = 22'($urandom);
            alarm_clock_in = 22'($urandom);
            timer_value    = 17'($urandom);
            a  = 3'($urandom_range(0, 7));
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (wr && a <= 3'd1 && $urandom_range(0, 1) == 1)
                d = {d[31], 9'b0, make_bcd($urandom_range(0, 23), $urandom_range(0, 59),
                                           $urandom_range(0, 59))};
            xfer(wr, a, d, 0);
            if (i % 4 == 0) pulse_inputs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_irq();
        end

        // Reset while an alarm update pulse is on the wire
        @(negedge clk);
        psel = 1; penable = 0; pwrite = 1; paddr = {7'b0, 3'd1, 2'b00}; pwdata = 32'h8010_2030;
        @(negedge clk);
        penable = 1;
        @(negedge clk); #1;
        check("alarm_pulse_before_reset", 32'(alarm_update), 32'd1);
        rstn = 0;
        #1;
        check("alarm_pulse_async_drop", 32'(alarm_update), 32'd0);
        psel = 0; penable = 0; pwrite = 0;
        model_reset();
        @(negedge clk);
        rstn = 1;
        #1;
        check_quiet_outputs();
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("no_reissue", 32'({clock_update, alarm_update, timer_update}), 32'd0);
        end
        xfer(0, 3'd5, 32'd0, 0);
        xfer(0, 3'd1, 32'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_apb_ctrl.md
# rtc_apb_ctrl

APB register front-end and sequencer for the RTC time-of-day block. Owns the software-visible registers and BCD-validates writes. Converts register writes into single-cycle update pulses with held data toward the RTC core. Also keeps a day counter, collects RTC events into a maskable interrupt and gives software a coherent clock/day read.

## Interface
Parameters:
- APB_ADDR_WIDTH, 12, width of paddr_i; only paddr_i[4:2] decoded.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- psel_i, penable_i, pwrite_i  in  1 each  APB control
- paddr_i  in  APB_ADDR_WIDTH  APB address
- pwdata_i  in  32  APB write data
- prdata_o  out  32  APB read data
- pready_o, pslverr_o  out  1 each  APB response
- clock_update_o  out  1  one-cycle load pulse to core clock
- clock_o  out  22  BCD {hh[5:0],mm[7:0],ss[7:0]} load value
- clock_i  in  22  current core clock
- init_sec_cnt_o  out  10  sub-second preset
- timer_update_o  out  1  one-cycle timer config pulse
- timer_enable_o, timer_retrig_o  out  1 each  timer config
- timer_target_o  out  17  timer target
- timer_value_i  in  17  current timer count
- alarm_update_o  out  1  one-cycle alarm config pulse
- alarm_enable_o  out  1  alarm enable
- alarm_clock_o  out  22  alarm BCD value
- alarm_clock_i  in  22  alarm value held in core
- event_i  in  1  alarm/timer event pulse from core
- update_day_i  in  1  midnight rollover pulse from core
- irq_o  out  1  registered interrupt

## Operation
Register map (word offset, paddr_i[4:2]):
- 0 CLOCK rw: [21:0] write -> clock load; read = clock_i; a read also latches day_cnt into day_shadow.
- 1 ALARM rw: [31] enable, [21:0] value; read = {alarm_en_q, 9'b0, alarm_clock_i}.
- 2 TIMER_CFG rw: [31] enable, [30] retrig, [16:0] target; read returns the held values.
- 3 TIMER_VAL ro: [16:0] timer_value_i; write -> pslverr.
- 4 IRQ_STATUS w1c: [0] event, [1] day rollover.
- 5 IRQ_MASK rw: [1:0], reset 0.
- 6 DAY_CNT rw: write loads day_cnt[15:0]; read returns day_shadow.
- 7 SEC_INIT rw: [9:0] driven continuously on init_sec_cnt_o.

BCD validation (CLOCK, ALARM writes):
- Each nibble must be <=9.
- ss<=0x59, mm<=0x59, hh<=0x23.
- Failure -> pslverr_o=1, no pulse, no state change.

Sequencer FSM, states IDLE, PULSE, DONE:
- IDLE: a valid write to CLOCK/ALARM/TIMER_CFG in an access phase (psel&penable&pwrite) captures pwdata_i into the output holding registers, then -> PULSE. pready_o=0.
- PULSE: exactly one of clock/alarm/timer_update_o =1 -> DONE. pready_o=0.
- DONE: pready_o=1 -> IDLE.
- All other accesses (reads, other writes, errors) complete in IDLE with pready_o=1 in the first access cycle.

Day counter and interrupts:
- day_cnt: 16-bit, +1 on update_day_i, wraps 0xFFFF->0x0000. A DAY_CNT write in the same cycle wins.
- status[0] sets on event_i; status[1] sets on update_day_i. W1C clears; a set in the same cycle wins over the clear.
- irq_o = registered |(status & mask).

Unmapped addresses do not exist (all 8 decoded). prdata_o is 0 when not reading.

## Timing
- Reset values: all outputs 0, prdata_o 0, FSM IDLE, day_cnt/day_shadow/status/mask 0, holding registers 0.
- Update writes take 3 access cycles: A0 capture, A1 pulse, A2 pready. Data outputs are stable from A1 onward and hold until the next write to the same register.
- Read/other write/error: 0 wait states. prdata_o is combinational from current inputs and registers.
- irq_o lags the status/mask change by 1 cycle.
- Reset asserted mid-sequence: FSM -> IDLE immediately, pulse outputs drop asynchronously, no partial update is re-issued.
- psel_i dropped while in PULSE/DONE (protocol violation): the sequence still completes and returns to IDLE.

## Test plan
- Write CLOCK=0x123059 -> A1 clock_update_o=1 with clock_o=0x123059; A2 pready_o=1; pslverr_o=0 throughout.
- Write CLOCK=0x245900 (hh invalid) and ALARM=0x00005A -> pready_o=1, pslverr_o=1 in A0; no update pulses; clock_o unchanged.
- Write TIMER_CFG=0xC0000010 -> timer_update_o one cycle with enable=1, retrig=1, target=0x10. Read TIMER_VAL returns timer_value_i; write to TIMER_VAL -> pslverr_o=1.
- Set DAY_CNT=0xFFFF, pulse update_day_i -> day_cnt=0. Read CLOCK then DAY_CNT returns 0x0000 and status[1]=1. With mask=0x2, irq_o=1 one cycle later.
- event_i pulse in the same cycle as a W1C of 0x1 -> status[0] stays 1. A later W1C clears it and irq_o falls 1 cycle after.
- Assert rstn_i low during PULSE -> alarm_update_o drops immediately. After release: IDLE, all outputs 0, next read completes with 0 wait states.
